// File: rtl/bank_monitor.sv
// Passive 6509 bus monitor: shadows the $0000/$0001 bank registers and checks A19..A16 on every bus cycle.
// Build option BANK_ERR_CAPTURE_EN enables err_addr/err_valid capture of the first mismatch; otherwise both read 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | normal execution, every cycle predicted from exec_bank
// S_C2   | cycle 2 of (zp),Y: zero-page pointer operand fetch
// S_C3   | cycle 3: pointer low byte read
// S_C4   | cycle 4: pointer high byte read
// S_C5   | cycle 5: indirect data access (predicted from ind_bank)
// S_C6   | cycle 6: page-cross data access (sync=0) or next opcode fetch
module bank_monitor #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 _reset,
  input  logic                 phi2_6509,
  input  logic                 r_w,
  input  logic [15:0]          address_cpu,
  input  logic [3:0]           address_bank,
  input  logic [7:0]           data_cpu,
  input  logic                 sync,
  input  logic                 rdy,
  output logic [3:0]           exec_bank,
  output logic [3:0]           ind_bank,
  output logic [3:0]           expected_bank,
  output logic                 indy_active,
  output logic                 bank_err,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [19:0]          err_addr,
  output logic                 err_valid
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_C2   = 3'd1,
    S_C3   = 3'd2,
    S_C4   = 3'd3,
    S_C5   = 3'd4,
    S_C6   = 3'd5
  } state_t;

  state_t state, state_next;

  logic phi_s1, phi_s2, phi_prev;
  logic        lat_r_w, lat_sync, lat_rdy;
  logic [15:0] lat_addr;
  logic [3:0]  lat_bank;
  logic [7:0]  lat_data;

  logic       cycle_end, stall, live, is_ptr, opc_match, mismatch, cmp_err;
  logic [3:0] pred_bank;

  // Bus cycle ends on the falling edge of the synchronized phi2.
  assign cycle_end = phi_prev & ~phi_s2;
  assign stall     = ~lat_rdy & lat_r_w;
  assign live      = cycle_end & ~stall;
  assign is_ptr    = (lat_addr[15:1] == 15'd0);
  // LDA/STA (zp),Y family: $91 / $B1, bit 5 is don't-care.
  assign opc_match = lat_sync & lat_rdy & ((lat_data & 8'hDF) == 8'h91);

  always_ff @(posedge clock) begin
    if (!_reset) begin
      phi_s1   <= 1'b0;
      phi_s2   <= 1'b0;
      phi_prev <= 1'b0;
      lat_r_w  <= 1'b0;
      lat_sync <= 1'b0;
      lat_rdy  <= 1'b0;
      lat_addr <= 16'h0000;
      lat_bank <= 4'h0;
      lat_data <= 8'h00;
    end else begin
      phi_s1   <= phi2_6509;
      phi_s2   <= phi_s1;
      phi_prev <= phi_s2;
      if (phi_s2) begin
        lat_r_w  <= r_w;
        lat_sync <= sync;
        lat_rdy  <= rdy;
        lat_addr <= address_cpu;
        lat_bank <= address_bank;
        lat_data <= data_cpu;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!_reset) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    pred_bank  = exec_bank;
    case (state)
      S_C5:    pred_bank = ind_bank;
      S_C6:    pred_bank = lat_sync ? exec_bank : ind_bank;
      default: pred_bank = exec_bank;
    endcase
    if (live) begin
      case (state)
        S_IDLE:  state_next = opc_match ? S_C2 : S_IDLE;
        S_C2:    state_next = S_C3;
        S_C3:    state_next = S_C4;
        S_C4:    state_next = S_C5;
        S_C5:    state_next = S_C6;
        S_C6:    state_next = (lat_sync && opc_match) ? S_C2 : S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign indy_active = (state != S_IDLE);
  assign mismatch    = live & ~is_ptr & (lat_bank != pred_bank);

  // Shadow writes use the old bank values for this cycle's prediction.
  always_ff @(posedge clock) begin
    if (!_reset) begin
      exec_bank     <= 4'hF;
      ind_bank      <= 4'hF;
      expected_bank <= 4'hF;
    end else if (live) begin
      expected_bank <= pred_bank;
      if (!lat_r_w && is_ptr) begin
        if (lat_addr[0]) ind_bank  <= lat_data[3:0];
        else             exec_bank <= lat_data[3:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!_reset) begin
      cmp_err   <= 1'b0;
      bank_err  <= 1'b0;
      err_count <= '0;
    end else begin
      cmp_err  <= mismatch;
      bank_err <= cmp_err;
      if (bank_err && (err_count != {CNT_WIDTH{1'b1}}))
        err_count <= err_count + CNT_WIDTH'(1);
    end
  end

`ifdef BANK_ERR_CAPTURE_EN
  logic [19:0] cap_addr;
  logic        cap_valid;

  always_ff @(posedge clock) begin
    if (!_reset) begin
      cap_addr  <= 20'h00000;
      cap_valid <= 1'b0;
    end else if (mismatch && !cap_valid) begin
      cap_addr  <= {lat_bank, lat_addr};
      cap_valid <= 1'b1;
    end
  end

  assign err_addr  = cap_addr;
  assign err_valid = cap_valid;
`else
  assign err_addr  = 20'h00000;
  assign err_valid = 1'b0;
`endif

endmodule
